cover_example_stimulus_gen: RTL and testbench
=============================================

// Module: cover_example_stimulus_gen
// PURPOSE
//  Stimulus generator for the a-then-b cover checker FSM: drives 'a' and 'b' to complete the covered sequence
//  once per start request, with a programmable idle gap between a and b. Samples the checker's
//  assertion_active output at two fixed points to confirm the sequence was observed.
//  Sits in cocotb/formal harnesses between the test controller and the checker RTL.
// PARAMETERS
//  GAP_W  8   width of gap_cycles and internal gap counter
//  CNT_W  16  width of seq_count (saturating)
// PORTS
//  clk            in   1      clock, all logic on posedge
//  rst_n          in   1      synchronous active-low reset
//  start          in   1      request one sequence; sampled only in IDLE
//  gap_cycles     in   GAP_W  idle cycles between a pulse and b pulse; latched on accepted start
//  abort          in   1      cancel in-flight sequence
//  clr_err        in   1      clear sticky error flags
//  chk_active     in   1      checker assertion_active feedback
//  a              out  1      drive to checker 'a'
//  b              out  1      drive to checker 'b'
//  busy           out  1      sequence in flight (state != IDLE)
//  done           out  1      one-cycle pulse, sequence completed
//  err_s1         out  1      sticky: chk_active low the cycle after the a pulse
//  err_s2         out  1      sticky: chk_active low the cycle after the b pulse
//  seq_count      out  CNT_W  completed error-free sequences, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, gap_q=0, gap_cnt=0, seq_count=0, err_s1=err_s2=0, run_err=0;
//   hence a=b=busy=done=0. Reset mid-sequence aborts immediately; no done, no count.
//  States: IDLE, DRIVE_A, GAP, DRIVE_B, CHECK. a/b/busy/done are Moore decodes of state register:
//   a=(DRIVE_A), b=(DRIVE_B), busy=(state!=IDLE), done=(CHECK).
//  IDLE: start=1 -> latch gap_q=gap_cycles, clear run_err, go DRIVE_A. start while busy ignored.
//  DRIVE_A (1 cycle): gap_q==0 -> DRIVE_B; else gap_cnt=1, -> GAP.
//  GAP: a=b=0; first GAP cycle (gap_cnt==1) samples chk_active; gap_cnt==gap_q -> DRIVE_B else gap_cnt++.
//  DRIVE_B (1 cycle): if gap_q==0 this is the cycle after DRIVE_A and chk_active is sampled here; -> CHECK.
//  S1 check: chk_active==0 in cycle after DRIVE_A -> set err_s1 and run_err.
//  CHECK (1 cycle): done=1; chk_active==0 -> set err_s2 and run_err; -> IDLE.
//   On CHECK->IDLE: seq_count++ if run_err==0 and current-cycle chk_active==1 and seq_count!=max.
//  Latency: start sampled at edge 0 -> a high cycle 1, GAP cycles 2..G+1, b high cycle G+2,
//   done cycle G+3; busy cycles 1..G+3. Total G+3 cycles; gap_cycles=max gives 2^GAP_W+2.
//  abort=1 while busy (any non-IDLE state incl. CHECK) -> IDLE next edge, no done pulse after, no count,
//   error flags already set remain. abort in IDLE ignored. abort has priority over all transitions.
//  clr_err clears err_s1/err_s2 next edge; a same-cycle error set wins over clr_err.
//  Checker has no return path from its S2, so chk_active stays 1 on later runs; checks still apply.
//  Illegal state encoding -> IDLE next edge.
// TESTING
//  T1 gap=3, checker connected: start pulse -> a=1 cycle 1, b=1 cycle 5, done cycle 6, seq_count=1, no errors.
//  T2 gap=0: start -> a cycle 1, b cycle 2, done cycle 3; chk_active sampled in cycle 2; seq_count=1.
//  T3 chk_active tied 0, gap=2: start -> err_s1=1 and err_s2=1 after done, seq_count unchanged; clr_err -> both 0.
//  T4 gap=5, abort in GAP cycle 3 -> busy=0 next cycle, b never asserted, no done, seq_count unchanged.
//  T5 rst_n=0 during DRIVE_B -> next cycle all outputs 0, seq_count=0; start while busy ignored (one done only).
//  T6 CNT_W=2: run 5 error-free sequences -> seq_count saturates at 3.

Source files
------------

// File: rtl/cover_example_stimulus_gen.sv
// Stimulus generator for the a-then-b cover checker. Each accepted start request drives
// one 'a' pulse, waits a programmable number of idle cycles, drives one 'b' pulse, then
// checks the checker's assertion_active feedback after each pulse.
module cover_example_stimulus_gen #(
   parameter int unsigned GAP_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [GAP_W-1:0] gap_cycles,
   input  logic             abort,
   input  logic             clr_err,
   input  logic             chk_active,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             err_s1,
   output logic             err_s2,
   output logic [CNT_W-1:0] seq_count
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StDriveA = 3'd1,
      StGap    = 3'd2,
      StDriveB = 3'd3,
      StCheck  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] seq_count_q, seq_count_d;
   logic             err_s1_q, err_s1_d;
   logic             err_s2_q, err_s2_d;
   logic             run_err_q, run_err_d;

   logic             s1_sample;
   logic             s1_fail;
   logic             s2_fail;

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         seq_count_q <= '0;
         err_s1_q    <= 1'b0;
         err_s2_q    <= 1'b0;
         run_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         seq_count_q <= seq_count_d;
         err_s1_q    <= err_s1_d;
         err_s2_q    <= err_s2_d;
         run_err_q   <= run_err_d;
      end
   end

   // Next-state logic: sequencing, feedback sampling, error flags and completion count.
   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      seq_count_d = seq_count_q;
      err_s1_d    = err_s1_q;
      err_s2_d    = err_s2_q;
      run_err_d   = run_err_q;

      // The cycle after the a pulse is the first GAP cycle, or DRIVE_B when there is no gap.
      s1_sample = ((state_q == StGap) && (gap_cnt_q == GAP_W'(1))) ||
                  ((state_q == StDriveB) && (gap_q == '0));
      s1_fail   = s1_sample && !chk_active;
      s2_fail   = (state_q == StCheck) && !chk_active;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               gap_d     = gap_cycles;
               run_err_d = 1'b0;
               state_d   = StDriveA;
            end
         end
         StDriveA: begin
            if (gap_q == '0) begin
               state_d = StDriveB;
            end else begin
               gap_cnt_d = GAP_W'(1);
               state_d   = StGap;
            end
         end
         StGap: begin
            if (gap_cnt_q == gap_q) begin
               state_d = StDriveB;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         StDriveB: begin
            state_d = StCheck;
         end
         StCheck: begin
            state_d = StIdle;
            if (!run_err_q && chk_active && (seq_count_q != '1)) begin
               seq_count_d = seq_count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort beats every transition and suppresses the count of an in-flight CHECK.
      if (abort && (state_q != StIdle)) begin
         state_d     = StIdle;
         seq_count_d = seq_count_q;
      end

      // Clear first so a same-cycle error set takes precedence.
      if (clr_err) begin
         err_s1_d = 1'b0;
         err_s2_d = 1'b0;
      end
      if (s1_fail) begin
         err_s1_d  = 1'b1;
         run_err_d = 1'b1;
      end
      if (s2_fail) begin
         err_s2_d  = 1'b1;
         run_err_d = 1'b1;
      end
   end

   // Moore output decode of the state register.
   always_comb begin
      a         = (state_q == StDriveA);
      b         = (state_q == StDriveB);
      busy      = (state_q != StIdle);
      done      = (state_q == StCheck);
      err_s1    = err_s1_q;
      err_s2    = err_s2_q;
      seq_count = seq_count_q;
   end

endmodule

// File: tb/tb_cover_example_stimulus_gen.sv
// Scoreboard bench: each issued sequence pushes its expected timing and end state; a monitor
// records what the DUT does while busy and compares when busy falls.
module tb_cover_example_stimulus_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  gap_cycles = '0;
   logic        abort = 1'b0;
   logic        clr_err = 1'b0;
   logic        chk_zero = 1'b0;
   logic        chk_active;
   logic        a, b, busy, done, err_s1, err_s2;
   logic [15:0] seq_count;

   // Second instance with a 2-bit counter for saturation.
   logic        start2 = 1'b0;
   logic        a2, b2, busy2, done2, err2_s1, err2_s2;
   logic [1:0]  seq_count2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference checker model: S0 -a-> S1 -b-> S2, no return path.
   int cst = 0;
   always @(posedge clk) begin
      if (!rst_n) cst <= 0;
      else if (cst == 0 && a) cst <= 1;
      else if (cst == 1 && b) cst <= 2;
   end
   assign chk_active = chk_zero ? 1'b0 : (cst != 0);

   cover_example_stimulus_gen #(.GAP_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .gap_cycles(gap_cycles), .abort(abort),
      .clr_err(clr_err), .chk_active(chk_active), .a(a), .b(b), .busy(busy), .done(done),
      .err_s1(err_s1), .err_s2(err_s2), .seq_count(seq_count)
   );

   cover_example_stimulus_gen #(.GAP_W(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .gap_cycles(8'd1), .abort(1'b0),
      .clr_err(1'b0), .chk_active(1'b1), .a(a2), .b(b2), .busy(busy2), .done(done2),
      .err_s1(err2_s1), .err_s2(err2_s2), .seq_count(seq_count2)
   );

   typedef struct {
      int a_c;
      int b_c;
      int d_c;
      int end_c;
      int cnt;
      int s1;
      int s2;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: capture pulse cycles while busy, compare on the busy falling edge.
   int   seen_a = -1, seen_b = -1, seen_d = -1;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1 && !prev_busy) begin
         seen_a = -1;
         seen_b = -1;
         seen_d = -1;
      end
      if (a === 1'b1) seen_a = cyc;
      if (b === 1'b1) seen_b = cyc;
      if (done === 1'b1) seen_d = cyc;
      if (busy === 1'b0 && prev_busy) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_sequence actual=ended_at_%0d expected=none", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("a_cycle", seen_a, e.a_c);
            chk("b_cycle", seen_b, e.b_c);
            chk("done_cycle", seen_d, e.d_c);
            chk("busy_end_cycle", cyc, e.end_c);
            chk("seq_count", int'(seq_count), e.cnt);
            chk("err_s1", int'(err_s1), e.s1);
            chk("err_s2", int'(err_s2), e.s2);
         end
      end
      prev_busy = (busy === 1'b1);
   end

   // One sequence. kill_at: relative cycle of abort/reset (-1 none). Cycle t0 is the a cycle.
   task automatic run_seq(input int gap, input int cnt, input int s1, input int s2,
                          input int kill_at, input bit kill_rst, input int extra_start,
                          input int zero_from, input int zero_to);
      int   t0;
      exp_t e;
      @(negedge clk);
      gap_cycles = 8'(gap);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      e.a_c   = t0;
      e.b_c   = (kill_at < 0 || kill_at >= gap + 1) ? t0 + gap + 1 : -1;
      e.d_c   = (kill_at < 0 || kill_at >= gap + 2) ? t0 + gap + 2 : -1;
      e.end_c = (kill_at < 0) ? t0 + gap + 3 : t0 + kill_at + 1;
      e.cnt   = cnt;
      e.s1    = s1;
      e.s2    = s2;
      exp_q.push_back(e);
      for (int rel = 0; rel <= gap + 4; rel++) begin
         chk_zero = (rel >= zero_from && rel <= zero_to);
         abort    = (rel == kill_at) && !kill_rst;
         rst_n    = !((rel == kill_at) && kill_rst);
         start    = (rel == extra_start);
         @(negedge clk);
      end
      chk_zero = 1'b0;
      abort    = 1'b0;
      rst_n    = 1'b1;
      start    = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_err_s1", int'(err_s1), 0);
      chk("clr_err_s2", int'(err_s2), 0);
   endtask

   initial begin
      int  waited;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_a", int'(a), 0);
      chk("rst_b", int'(b), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err_s1", int'(err_s1), 0);
      chk("rst_err_s2", int'(err_s2), 0);
      chk("rst_seq_count", int'(seq_count), 0);

      // T1: gap 3 with checker model.
      run_seq(3, 1, 0, 0, -1, 1'b0, -1, -1, -2);
      // T2: gap 0.
      run_seq(0, 2, 0, 0, -1, 1'b0, -1, -1, -2);
      // T2b: gap 0, feedback low only in the DRIVE_B cycle -> s1 error only.
      run_seq(0, 2, 1, 0, -1, 1'b0, -1, 1, 1);
      pulse_clr();
      // T3: feedback tied low, gap 2.
      run_seq(2, 2, 1, 1, -1, 1'b0, -1, 0, 10);
      pulse_clr();
      // T4: gap 5, abort in a GAP cycle.
      run_seq(5, 2, 0, 0, 3, 1'b0, -1, -1, -2);
      // T5: gap 1, reset during DRIVE_B.
      run_seq(1, 0, 0, 0, 2, 1'b1, -1, -1, -2);
      // T5b: start while busy is ignored.
      run_seq(1, 1, 0, 0, -1, 1'b0, 1, -1, -2);
      repeat (8) @(negedge clk);
      // Maximum gap.
      run_seq(255, 2, 0, 0, -1, 1'b0, -1, -1, -2);

      // T6: 2-bit counter saturation.
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         start2 = 1'b1;
         @(negedge clk);
         start2 = 1'b0;
         waited = 0;
         while (busy2 === 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
         end
         if (waited >= 10) begin
            checks++;
            failures++;
            $display("FAIL sat_timeout actual=busy expected=idle");
         end
         chk("sat_seq_count", int'(seq_count2), (i < 3) ? i : 3);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
